// File: rtl/one_wire_pkg.sv
// rtl/one_wire_pkg.sv - state encoding, counter width and us-to-clock conversion shared by one_wire blocks
package one_wire_pkg;

  localparam int CNT_W = 15;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOW       = 2'd1,
    S_PRES_WAIT = 2'd2,
    S_PRES      = 2'd3
  } ow_state_e;

  function automatic logic [CNT_W-1:0] us_to_clk(input int us, input int clk_mhz);
    return CNT_W'(us * clk_mhz);
  endfunction

endpackage

// File: rtl/one_wire_filter.sv
// rtl/one_wire_filter.sv - 2-flop line synchroniser with edge outputs; OW_GLITCH_FILTER_EN adds a 4-sample filter
module one_wire_filter (
  input  logic clk,
  input  logic reset_n,
  input  logic wire_i,
  output logic level_o,
  output logic fall_o,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       lvl;

  // Idle 1-wire line is high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], wire_i};
      prev_q <= lvl;
    end
  end

`ifdef OW_GLITCH_FILTER_EN
  logic       filt_q;
  logic [1:0] run_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 1'b1;
      run_q  <= 2'd0;
    end else if (sync_q[1] == filt_q) begin
      run_q  <= 2'd0;
    end else if (run_q == 2'd3) begin
      filt_q <= sync_q[1];
      run_q  <= 2'd0;
    end else begin
      run_q  <= run_q + 2'd1;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q[1];
`endif

  assign level_o = lvl;
  assign fall_o  = prev_q & ~lvl;
  assign rise_o  = ~prev_q & lvl;

endmodule

// File: rtl/one_wire_slave.sv
// rtl/one_wire_slave.sv - 1-wire slave: bus reset/presence, write-slot receive, read-slot transmit
module one_wire_slave
  import one_wire_pkg::*;
#(
  parameter int CLK_MHZ       = 24,
  parameter int T_SAMP_US     = 30,
  parameter int T_SLOT_MAX_US = 120,
  parameter int T_RST_US      = 400,
  parameter int T_PDH_US      = 30,
  parameter int T_PDL_US      = 120
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wire_in,
  output logic       wire_oe,
  input  logic [7:0] tx_byte,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       reset_det,
  output logic       presence_done,
  output logic       slot_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] T_SAMP     = us_to_clk(T_SAMP_US, CLK_MHZ);
  localparam logic [CNT_W-1:0] T_SLOT_MAX = us_to_clk(T_SLOT_MAX_US, CLK_MHZ);
  localparam logic [CNT_W-1:0] T_RST      = us_to_clk(T_RST_US, CLK_MHZ);
  localparam logic [CNT_W-1:0] T_PDH_END  = us_to_clk(T_PDH_US, CLK_MHZ) - CNT_W'(1);
  localparam logic [CNT_W-1:0] T_PDL_END  = us_to_clk(T_PDL_US, CLK_MHZ) - CNT_W'(1);

  logic level, fall, rise;

  one_wire_filter u_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .wire_i  (wire_in),
    .level_o (level),
    .fall_o  (fall),
    .rise_o  (rise)
  );

  ow_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             tx_busy_q, tx_busy_d, tx_mode_q, tx_mode_d;
  logic [7:0]       tx_buf_q, tx_buf_d, rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
  logic             samp_q, samp_d, wire_oe_q, wire_oe_d;
  logic             rx_valid_q, rx_valid_d, reset_det_q, reset_det_d;
  logic             pres_done_q, pres_done_d, slot_err_q, slot_err_d;
  logic             go_low;

  always_comb begin
    state_d     = state_q;
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    cnt_d       = cnt_inc;
    bit_idx_d   = bit_idx_q;
    tx_busy_d   = tx_busy_q;
    tx_mode_d   = tx_mode_q;
    tx_buf_d    = tx_buf_q;
    rx_shift_d  = rx_shift_q;
    rx_byte_d   = rx_byte_q;
    samp_d      = samp_q;
    rx_valid_d  = 1'b0;
    reset_det_d = 1'b0;
    pres_done_d = 1'b0;
    slot_err_d  = 1'b0;
    go_low      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        go_low = fall;
      end
      S_LOW: begin
        if (cnt_q == T_SAMP) samp_d = level;
        if (rise) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (cnt_q <= T_SLOT_MAX) begin
            bit_idx_d = bit_idx_q + 3'd1;
            if (!tx_mode_q) rx_shift_d = {samp_d, rx_shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              if (tx_mode_q) begin
                tx_busy_d = 1'b0;
                tx_mode_d = 1'b0;
              end else begin
                rx_byte_d  = rx_shift_d;
                rx_valid_d = 1'b1;
              end
            end
          end else begin
            bit_idx_d = 3'd0;
            tx_busy_d = 1'b0;
            tx_mode_d = 1'b0;
            if (cnt_q < T_RST) begin
              slot_err_d = 1'b1;
            end else begin
              reset_det_d = 1'b1;
              state_d     = S_PRES_WAIT;
            end
          end
        end
      end
      S_PRES_WAIT: begin
        if (fall) begin
          go_low = 1'b1;
        end else if (cnt_q == T_PDH_END) begin
          state_d = S_PRES;
          cnt_d   = '0;
        end
      end
      S_PRES: begin
        if (cnt_q == T_PDL_END) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          pres_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Direction is decided only at a byte boundary so a partial byte never flips mode.
    if (go_low) begin
      state_d = S_LOW;
      cnt_d   = '0;
      samp_d  = 1'b1;
      if (bit_idx_q == 3'd0) tx_mode_d = tx_busy_q;
    end

    if (tx_load && !tx_busy_q) begin
      tx_busy_d = 1'b1;
      tx_buf_d  = tx_byte;
    end

    wire_oe_d = (state_d == S_PRES) ||
                ((state_d == S_LOW) && tx_mode_d && !tx_buf_q[bit_idx_q] && (cnt_d < T_SAMP));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      tx_busy_q   <= 1'b0;
      tx_mode_q   <= 1'b0;
      tx_buf_q    <= 8'h00;
      rx_shift_q  <= 8'h00;
      rx_byte_q   <= 8'h00;
      samp_q      <= 1'b1;
      wire_oe_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      reset_det_q <= 1'b0;
      pres_done_q <= 1'b0;
      slot_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      tx_busy_q   <= tx_busy_d;
      tx_mode_q   <= tx_mode_d;
      tx_buf_q    <= tx_buf_d;
      rx_shift_q  <= rx_shift_d;
      rx_byte_q   <= rx_byte_d;
      samp_q      <= samp_d;
      wire_oe_q   <= wire_oe_d;
      rx_valid_q  <= rx_valid_d;
      reset_det_q <= reset_det_d;
      pres_done_q <= pres_done_d;
      slot_err_q  <= slot_err_d;
    end
  end

  assign wire_oe       = wire_oe_q;
  assign tx_ready      = ~tx_busy_q;
  assign rx_byte       = rx_byte_q;
  assign rx_valid      = rx_valid_q;
  assign reset_det     = reset_det_q;
  assign presence_done = pres_done_q;
  assign slot_err      = slot_err_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_one_wire_slave.sv
// tb/tb_one_wire_slave.sv - scoreboard bench for one_wire_slave; host modelled on an open-drain line
module tb_one_wire_slave;

  localparam int CLK_MHZ = 8;
  localparam logic [15:0] EV_RST  = 16'h0200;
  localparam logic [15:0] EV_PRES = 16'h0300;
  localparam logic [15:0] EV_SERR = 16'h0400;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       host_low;
  logic       wire_in, wire_oe;
  logic [7:0] tx_byte;
  logic       tx_load, tx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid, reset_det, presence_done, slot_err, busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  assign wire_in = ~(host_low | wire_oe);

  one_wire_slave #(.CLK_MHZ(CLK_MHZ)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wire_in       (wire_in),
    .wire_oe       (wire_oe),
    .tx_byte       (tx_byte),
    .tx_load       (tx_load),
    .tx_ready      (tx_ready),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .reset_det     (reset_det),
    .presence_done (presence_done),
    .slot_err      (slot_err),
    .busy          (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic ev_check(input logic [15:0] obs);
    if (exp_q.size() == 0) check_eq("event_unexpected", {16'h0, obs}, 32'h0);
    else                   check_eq("event", {16'h0, obs}, {16'h0, exp_q.pop_front()});
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid)      ev_check({8'h01, rx_byte});
      if (reset_det)     ev_check(EV_RST);
      if (presence_done) ev_check(EV_PRES);
      if (slot_err)      ev_check(EV_SERR);
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int us(input int t);
    return t * CLK_MHZ;
  endfunction

  task automatic host_reset();
    exp_q.push_back(EV_RST);
    exp_q.push_back(EV_PRES);
    host_low = 1'b1;
    clks(us(480));
    check_eq("busy_in_reset", {31'h0, busy}, 32'h1);
    host_low = 1'b0;
    clks(us(20));
    check_eq("pdh_oe", {31'h0, wire_oe}, 32'h0);
    clks(us(20));
    check_eq("pres_oe", {31'h0, wire_oe}, 32'h1);
    clks(us(100));
    check_eq("pres_oe_late", {31'h0, wire_oe}, 32'h1);
    clks(us(20));
    check_eq("pres_end_oe", {31'h0, wire_oe}, 32'h0);
    clks(us(10));
  endtask

  task automatic write_bit(input logic b);
    host_low = 1'b1;
    clks(b ? us(6) : us(60));
    host_low = 1'b0;
    clks(us(10));
  endtask

  task automatic write_bits(input logic [7:0] v, input int from);
    for (int i = from; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic write_byte(input logic [7:0] v);
    exp_q.push_back({8'h01, v});
    write_bits(v, 0);
  endtask

  task automatic read_bit(input logic exp_b);
    host_low = 1'b1;
    clks(us(2));
    host_low = 1'b0;
    clks(us(13));
    check_eq("read_bit", {31'h0, wire_in}, {31'h0, exp_b});
    clks(us(55));
    clks(us(10));
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    reset_n  = 1'b0;
    host_low = 1'b0;
    tx_byte  = 8'h00;
    tx_load  = 1'b0;
    clks(3);
    check_eq("rst_wire_oe", {31'h0, wire_oe}, 32'h0);
    check_eq("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
    check_eq("rst_rx_byte", {24'h0, rx_byte}, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_pulses", {28'h0, rx_valid, reset_det, presence_done, slot_err}, 32'h0);
    reset_n = 1'b1;
    clks(us(10));

    host_reset();
    write_byte(8'hA5);

    tx_byte = 8'h3C;
    tx_load = 1'b1;
    clks(1);
    tx_load = 1'b0;
    check_eq("tx_ready_loaded", {31'h0, tx_ready}, 32'h0);
    tx_byte = 8'hFF;
    tx_load = 1'b1;
    clks(1);
    tx_load = 1'b0;
    b = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      read_bit(b[i]);
      if (i == 6) check_eq("tx_ready_mid", {31'h0, tx_ready}, 32'h0);
    end
    check_eq("tx_ready_done", {31'h0, tx_ready}, 32'h1);

    write_bits(8'h00, 5);
    exp_q.push_back(EV_SERR);
    host_low = 1'b1;
    clks(us(200));
    host_low = 1'b0;
    clks(us(10));
    write_byte(8'h01);

    exp_q.push_back(EV_RST);
    host_low = 1'b1;
    clks(us(480));
    host_low = 1'b0;
    clks(us(40));
    check_eq("pres_before_abort", {31'h0, wire_oe}, 32'h1);
    reset_n = 1'b0;
    #1;
    check_eq("abort_oe", {31'h0, wire_oe}, 32'h0);
    check_eq("abort_busy", {31'h0, busy}, 32'h0);
    clks(5);
    reset_n = 1'b1;
    clks(us(10));
    host_reset();

    exp_q.push_back({8'h01, 8'h4B});
`ifdef OW_GLITCH_FILTER_EN
    host_low = 1'b1;
    clks(2);
    host_low = 1'b0;
    clks(us(10));
    write_bits(8'h4B, 0);
`else
    host_low = 1'b1;
    clks(2);
    host_low = 1'b0;
    clks(us(10));
    write_bits(8'h4B, 1);
`endif

    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom);
      write_byte(b);
    end

    clks(us(20));
    check_eq("scoreboard_empty", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/one_wire_slave.md
ONE_WIRE_SLAVE -- requirements
Module: one_wire_slave

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 24, clock frequency in MHz; all times scale as us*CLK_MHZ clocks.
REQ-002 SHALL have parameter T_SAMP_US, default 30, sample/drive point after slot falling edge.
REQ-003 SHALL have parameter T_SLOT_MAX_US, default 120, longest low time still accepted as a bit slot.
REQ-004 SHALL have parameter T_RST_US, default 400, minimum low time recognised as a bus reset.
REQ-005 SHALL have parameters T_PDH_US, default 30, and T_PDL_US, default 120: presence wait and presence low times.
REQ-006 SHALL have port clk  input  1  system clock, 24 MHz.
REQ-007 SHALL have port reset_n  input  1  one clock; reset is asynchronous and active-low.
REQ-008 SHALL have port wire_in  input  1  1-wire line level (asynchronous).
REQ-009 SHALL have port wire_oe  output  1  1 = pull line low; 0 = release. Top level builds the open-drain pad.
REQ-010 SHALL have ports tx_byte  input  8  and tx_load  input  1: byte to send in the next 8 read slots, loaded on tx_load high.
REQ-011 SHALL have port tx_ready  output  1  high when no tx byte is pending or in progress.
REQ-012 SHALL have ports rx_byte  output  8  and rx_valid  output  1: received byte, rx_valid is a one-clock pulse.
REQ-013 SHALL have ports reset_det  output  1, presence_done  output  1, slot_err  output  1: one-clock event pulses.
REQ-014 SHALL have port busy  output  1  high in any state other than S_IDLE.

Function
REQ-015 SHALL synchronise wire_in through 2 flops; edges SHALL be detected on the synchronised level.
REQ-016 SHALL implement states S_IDLE, S_LOW, S_PRES_WAIT, S_PRES; S_IDLE->S_LOW on falling edge, with a 15-bit counter cleared on entry and saturating at all-ones.
REQ-017 In S_LOW, tx mode, current bit 0: wire_oe SHALL be 1 from the clock after the edge until count == T_SAMP; bit 1 SHALL leave wire_oe 0.
REQ-018 In S_LOW, rx mode: line level SHALL be captured at count == T_SAMP.
REQ-019 On rising edge in S_LOW with count <= T_SLOT_MAX: bit SHALL commit, LSB first, with bit index +1 and return to S_IDLE.
REQ-020 After 8 rx bits: rx_byte updated and rx_valid pulsed in the same clock; after 8 tx bits: tx_ready SHALL rise.
REQ-021 On rising edge with T_SLOT_MAX < count < T_RST: slot_err SHALL pulse; bit index and any pending tx SHALL clear; next state S_IDLE.
REQ-022 On rising edge with count >= T_RST: reset_det SHALL pulse; bit index and tx SHALL clear; next state S_PRES_WAIT.
REQ-023 S_PRES_WAIT SHALL count T_PDH, then enter S_PRES; S_PRES SHALL hold wire_oe=1 for T_PDL, then pulse presence_done and enter S_IDLE.
REQ-024 A falling edge seen during S_PRES_WAIT SHALL abort the presence pulse and enter S_LOW (new reset or slot).
REQ-025 tx_load SHALL be accepted only when tx_ready=1, and ignored otherwise; once accepted, the byte SHALL take effect at the next slot boundary (bit index 0).
REQ-026 Tx/rx mode SHALL be fixed per byte at bit index 0; a partial byte SHALL never switch mode.

Reset
REQ-027 While reset_n=0: state S_IDLE, wire_oe=0, tx_ready=1, rx_byte=0, all pulses/busy=0, counter and bit index 0; synchroniser flops SHALL reset to 1 (idle-high line).

Configuration
REQ-028 Macro OW_GLITCH_FILTER_EN defined: synchronised level SHALL update only after 4 consecutive equal samples, adding 4 clocks edge latency. Undefined: 2-flop synchroniser only.

Structure
REQ-029 Package one_wire_pkg SHALL hold the state encoding, us-to-clock conversion constant, and counter width, shared with one_wire.
REQ-030 Sub-module one_wire_filter (synchroniser plus optional glitch filter, edge outputs) SHALL be instantiated once.

Verification
REQ-031 Host low 480us, release -> reset_det at release; wire_oe=1 from +30us for 120us; then presence_done.
REQ-032 Host write-slot sequence for 0xA5 (LSB first, 0 = low 60us, 1 = low 6us) -> rx_valid with rx_byte=0xA5 at the 8th release.
REQ-033 tx_load with 0x3C, then 8 host read slots (low 2us, sample 15us) -> reads 0,0,1,1,1,1,0,0; tx_ready=1 after the 8th slot.
REQ-034 Low 200us mid-byte -> slot_err pulse; next 8 write slots of 0x01 -> rx_byte=0x01.
REQ-035 reset_n asserted during S_PRES -> wire_oe=0 immediately; after release, a 480us reset yields a normal presence.
REQ-036 With OW_GLITCH_FILTER_EN, 2-clock low glitch -> no state change; without it -> slot_err not raised, but one bit committed.
